// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed program image over a byte stream,
// writes 32-bit instruction words to memory and releases the core on a good checksum.
// Ports: clk, rst_n (async, active-low); start (level, arms a new load);
//        rx_valid/rx_data in, rx_ready out: byte stream handshake;
//        imem_we/imem_addr/imem_wdata: one-cycle instruction memory write;
//        core_hold (core held in reset), done (good load), error (aborted load).
module prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_hold,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    logic [2:0]  state;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] shift;
    logic [7:0]  csum;
    logic [31:0] tcnt;
    logic        active;
    logic        accept;
    logic [15:0] len_rx;

    assign active = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                    (state == S_DATA)   || (state == S_CHECK);
    assign rx_ready  = active;
    assign accept    = rx_valid & active;
    assign len_rx    = {len_hi, rx_data};
    assign done      = (state == S_DONE);
    assign error     = (state == S_ERROR);
    assign core_hold = (state != S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            len_hi     <= 8'd0;
            len        <= 16'd0;
            word_idx   <= 16'd0;
            byte_cnt   <= 2'd0;
            shift      <= 24'd0;
            csum       <= 8'd0;
            tcnt       <= 32'd0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= 32'd0;
        end else begin
            // write strobe is a single-cycle pulse; addr/wdata hold otherwise
            imem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state    <= S_LEN_HI;
                        word_idx <= 16'd0;
                        byte_cnt <= 2'd0;
                        csum     <= 8'd0;
                        tcnt     <= 32'd0;
                    end
                end
                S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK: begin
                    if (accept) begin
                        tcnt <= 32'd0;
                        case (state)
                            S_LEN_HI: begin
                                len_hi <= rx_data;
                                state  <= S_LEN_LO;
                            end
                            S_LEN_LO: begin
                                len <= len_rx;
                                if (len_rx == 16'd0)
                                    state <= S_CHECK;
                                else if (32'(len_rx) > MAX_WORDS)
                                    state <= S_ERROR;
                                else
                                    state <= S_DATA;
                            end
                            S_DATA: begin
                                csum     <= csum ^ rx_data;
                                byte_cnt <= byte_cnt + 2'd1;
                                shift    <= {shift[15:0], rx_data};
                                // fourth byte completes the word; the write
                                // lands next cycle even if we move to CHECK
                                if (byte_cnt == 2'd3) begin
                                    imem_we    <= 1'b1;
                                    imem_addr  <= BASE_ADDR +
                                                  {14'd0, word_idx, 2'b00};
                                    imem_wdata <= {shift, rx_data};
                                    word_idx   <= word_idx + 16'd1;
                                    if (word_idx == len - 16'd1)
                                        state <= S_CHECK;
                                end
                            end
                            default: begin
                                state <= (rx_data == csum) ? S_DONE : S_ERROR;
                            end
                        endcase
                    end else if (tcnt >= TO_LAST) begin
                        state <= S_ERROR;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized self-checking bench for prog_loader.
// Frames are built from word lists; expected writes and status come from a frame-level model.
module tb_prog_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int MAXW = 256;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [63:0] wq[$];
    logic [31:0] fw[$];

    prog_loader #(
        .BASE_ADDR(BASE),
        .MAX_WORDS(MAXW),
        .TIMEOUT  (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_hold (core_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (rst_n && imem_we) wq.push_back({imem_addr, imem_wdata});

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] xsum();
        logic [7:0] x = 8'd0;
        foreach (fw[i])
            x ^= fw[i][31:24] ^ fw[i][23:16] ^ fw[i][15:8] ^ fw[i][7:0];
        return x;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 8 && rx_ready !== 1'b1; i++) @(negedge clk);
        if (rx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL rx_ready wait: got %b want 1", rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Frame-level model: words go to BASE+4k in order, status from XOR rule.
    task automatic run_frame(input logic [15:0] n, input logic [7:0] cs,
                             input int gap, input string tag);
        logic [63:0] exp[$];
        logic [7:0]  x;
        logic        exp_done;
        logic [31:0] w;
        wq.delete();
        pulse_start();
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
        exp_done = 1'b0;
        if (int'(n) <= MAXW) begin
            x = 8'd0;
            for (int k = 0; k < int'(n); k++) begin
                w = fw[k];
                for (int j = 3; j >= 0; j--) begin
                    send_byte(w[8*j +: 8], gap);
                    x ^= w[8*j +: 8];
                end
                exp.push_back({BASE + 32'(k) * 32'd4, w});
            end
            send_byte(cs, gap);
            exp_done = (x == cs);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (wq.size() !== exp.size())
            begin errors++; $display("FAIL %s write count: got %0d want %0d", tag, wq.size(), exp.size()); end
        else
            foreach (exp[i]) begin
                checks++;
                if (wq[i] !== exp[i])
                    begin errors++; $display("FAIL %s write %0d: got %h want %h", tag, i, wq[i], exp[i]); end
            end
        checks++;
        if (done !== exp_done)
            begin errors++; $display("FAIL %s done: got %b want %b", tag, done, exp_done); end
        checks++;
        if (error !== !exp_done)
            begin errors++; $display("FAIL %s error: got %b want %b", tag, error, !exp_done); end
        checks++;
        if (core_hold !== !exp_done)
            begin errors++; $display("FAIL %s core_hold: got %b want %b", tag, core_hold, !exp_done); end
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if (rx_ready !== 1'b0) begin errors++; $display("FAIL %s rx_ready: got %b want 0", tag, rx_ready); end
        checks++;
        if (imem_we !== 1'b0) begin errors++; $display("FAIL %s imem_we: got %b want 0", tag, imem_we); end
        checks++;
        if (imem_addr !== BASE) begin errors++; $display("FAIL %s imem_addr: got %h want %h", tag, imem_addr, BASE); end
        checks++;
        if (imem_wdata !== 32'd0) begin errors++; $display("FAIL %s imem_wdata: got %h want 0", tag, imem_wdata); end
        checks++;
        if (core_hold !== 1'b1) begin errors++; $display("FAIL %s core_hold: got %b want 1", tag, core_hold); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL %s done: got %b want 0", tag, done); end
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL %s error: got %b want 0", tag, error); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_idle("reset_low");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset_released");
    endtask

    task automatic test_good_load();
        fw = '{32'h2008_0005, 32'h0109_5020};
        run_frame(16'd2, xsum(), 0, "good");
        repeat (3) @(negedge clk);
        checks++;
        if (imem_addr !== BASE + 32'd4)
            begin errors++; $display("FAIL good addr hold: got %h want %h", imem_addr, BASE + 32'd4); end
        checks++;
        if (imem_wdata !== 32'h0109_5020)
            begin errors++; $display("FAIL good wdata hold: got %h want 01095020", imem_wdata); end
    endtask

    task automatic test_bad_checksum();
        fw = '{32'h2008_0005, 32'h0109_5020};
        run_frame(16'd2, 8'h00, 0, "badcs");
    endtask

    task automatic test_oversize();
        fw.delete();
        run_frame(16'd257, 8'h00, 0, "oversize");
        fw.delete();
        for (int i = 0; i < MAXW; i++) fw.push_back($urandom);
        run_frame(16'(MAXW), xsum(), 0, "maxlen");
    endtask

    task automatic test_zero_length();
        fw.delete();
        run_frame(16'd0, 8'h00, 0, "zero_ok");
        run_frame(16'd0, 8'h01, 0, "zero_bad");
    endtask

    task automatic test_timeout();
        wq.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        repeat (TMO - 1) @(negedge clk);
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL timeout early: got %b want 0", error); end
        @(negedge clk);
        checks++;
        if (error !== 1'b1) begin errors++; $display("FAIL timeout error: got %b want 1", error); end
        checks++;
        if (core_hold !== 1'b1 || done !== 1'b0)
            begin errors++; $display("FAIL timeout status: got hold=%b done=%b want 1 0", core_hold, done); end
        checks++;
        if (wq.size() !== 0) begin errors++; $display("FAIL timeout writes: got %0d want 0", wq.size()); end
        pulse_start();
        checks++;
        if (rx_ready !== 1'b1 || error !== 1'b0)
            begin errors++; $display("FAIL timeout rearm: got ready=%b err=%b want 1 0", rx_ready, error); end
        repeat (TMO) @(negedge clk);
        checks++;
        if (error !== 1'b1) begin errors++; $display("FAIL timeout len_hi: got %b want 1", error); end
    endtask

    task automatic test_reset_mid_load();
        wq.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h20, 0);
        send_byte(8'h08, 0);
        send_byte(8'h00, 0);
        rst_n = 1'b0;
        #1;
        check_idle("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (rx_ready !== 1'b0) begin errors++; $display("FAIL midreset needs start: got %b want 0", rx_ready); end
        checks++;
        if (wq.size() !== 0) begin errors++; $display("FAIL midreset writes: got %0d want 0", wq.size()); end
        fw = '{32'h2008_0005, 32'h0109_5020};
        run_frame(16'd2, xsum(), 0, "after_reset");
    endtask

    task automatic test_random_gaps();
        for (int r = 0; r < 4; r++) begin
            fw = '{32'h2008_0005, 32'h0109_5020};
            run_frame(16'd2, xsum(), 10, "gap_good");
        end
        for (int r = 0; r < 8; r++) begin
            int n;
            logic [7:0] cs;
            n = int'($urandom_range(8, 1));
            fw.delete();
            for (int i = 0; i < n; i++) fw.push_back($urandom);
            cs = xsum();
            if ($urandom_range(1, 0) == 1) cs ^= 8'(1 + $urandom_range(254, 0));
            run_frame(16'(n), cs, 12, "gap_rand");
        end
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_oversize();
        test_zero_length();
        test_timeout();
        test_reset_mid_load();
        test_random_gaps();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
